// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the sequential binary-to-BCD converter (bin2bcd_seq)
// and its per-digit add-3 correction cell (bcd_add3_digit).
//   - state_e        : converter FSM encoding (IDLE / SHIFT / DONE)
//   - BCD_DIGIT_W    : bits per packed BCD digit
//   - BCD_NINE       : largest legal BCD digit, used for saturation
//   - ADD3_THRESH    : digit value at or above which +3 is applied
//   - ADD3_INC       : the correction added to such digits
//   - bcd_add3()     : the double-dabble digit correction
// -----------------------------------------------------------------------------
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_NINE    = 4'd9;
  localparam logic [3:0] ADD3_THRESH = 4'd5;
  localparam logic [3:0] ADD3_INC    = 4'd3;

  // A digit of 5..9 becomes 8..12 so that the following left shift carries
  // correctly into the next decimal place. Values above 9 never occur in a
  // legal digit field; they map straight through the same rule.
  function automatic logic [3:0] bcd_add3(input logic [3:0] digit);
    logic [3:0] res;
    if (digit >= ADD3_THRESH) begin
      res = digit + ADD3_INC;
    end else begin
      res = digit;
    end
    return res;
  endfunction

endpackage : bcd_pkg

// File: rtl/bcd_add3_digit.sv
// -----------------------------------------------------------------------------
// bcd_add3_digit
// Combinational double-dabble correction for one BCD digit:
//   digit_o = (digit_i >= 5) ? digit_i + 3 : digit_i
// Ports:
//   digit_i  in  4  digit before correction
//   digit_o  out 4  digit after correction
// -----------------------------------------------------------------------------
module bcd_add3_digit
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  assign digit_o = bcd_add3(digit_i);

endmodule : bcd_add3_digit

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential binary-to-BCD converter (shift-and-add-3), one iteration per
// clock, start/done handshake. Feeds packed BCD digits to the BCD adder stage.
//
// Parameters:
//   BIN_W   binary operand width (>= 1)
//   DIGITS  number of BCD output digits (output is 4*DIGITS bits)
//
// Ports:
//   clk       in   1          rising-edge clock
//   rst_n     in   1          synchronous active-low reset
//   start     in   1          conversion request, sampled only when not busy
//   bin_in    in   BIN_W      operand, captured on the accepting edge
//   busy      out  1          iterations in progress
//   done      out  1          one-cycle pulse when results update
//   bcd_out   out  4*DIGITS   packed BCD result, digit 0 at [3:0]
//   overflow  out  1          value exceeded 10^DIGITS-1 (result saturated)
//   sign_out  out  1          result sign (signed build only, else 0)
//
// Optional feature: define BIN2BCD_SIGNED_EN to treat bin_in as two's
// complement; the magnitude is converted and the sign reported on sign_out.
// -----------------------------------------------------------------------------
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [BIN_W-1:0]            bin_in,
  output logic                        busy,
  output logic                        done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                        overflow,
  output logic                        sign_out
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Register state
  state_e             state_q;
  logic [SR_W-1:0]    sr_q;        // {digit field, remaining binary bits}
  logic [CNT_W-1:0]   cnt_q;
  logic               sticky_q;    // a 1 has left the top digit
  logic               sign_cap_q;  // sign captured with the operand
  logic               busy_q;
  logic               done_q;
  logic [BCD_W-1:0]   bcd_q;
  logic               ovf_q;
  logic               sign_q;

  // Next-state datapath values
  logic [BCD_W-1:0]   digits_adj_d;
  logic [SR_W-1:0]    sr_shift_d;
  logic               sticky_d;
  logic [BCD_W-1:0]   bcd_final_d;
  logic [BIN_W-1:0]   operand_d;
  logic               sign_d;

  // Per-digit add-3 correction, all digits in parallel, no inter-digit carry.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_add3_digit u_add3 (
      .digit_i (sr_q[BIN_W + BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .digit_o (digits_adj_d[BCD_DIGIT_W*g +: BCD_DIGIT_W])
    );
  end

  // One iteration: shift the corrected digits and binary bits left by one;
  // the corrected top-digit MSB falls off and feeds the sticky overflow.
  always_comb begin
    sr_shift_d  = {digits_adj_d[BCD_W-2:0], sr_q[BIN_W-1:0], 1'b0};
    sticky_d    = sticky_q | digits_adj_d[BCD_W-1];
    if (sticky_d) begin
      bcd_final_d = {DIGITS{BCD_NINE}};
    end else begin
      bcd_final_d = sr_shift_d[SR_W-1:BIN_W];
    end
  end

`ifdef BIN2BCD_SIGNED_EN
  // Two's complement operand: load the magnitude. The most-negative value
  // negates to itself, which read as unsigned is exactly its magnitude.
  always_comb begin
    sign_d = bin_in[BIN_W-1];
    if (sign_d) begin
      operand_d = ~bin_in + BIN_W'(1);
    end else begin
      operand_d = bin_in;
    end
  end
`else
  // Unsigned operand: loaded as is, sign is always positive.
  always_comb begin
    sign_d    = 1'b0;
    operand_d = bin_in;
  end
`endif

  // Converter FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      sticky_q   <= 1'b0;
      sign_cap_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      sign_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            sr_q       <= {{BCD_W{1'b0}}, operand_d};
            cnt_q      <= '0;
            sticky_q   <= 1'b0;
            sign_cap_q <= sign_d;
            busy_q     <= 1'b1;
            state_q    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          sr_q     <= sr_shift_d;
          sticky_q <= sticky_d;
          cnt_q    <= cnt_q + CNT_ONE;
          if (cnt_q == LAST_CNT) begin
            bcd_q   <= bcd_final_d;
            ovf_q   <= sticky_d;
            sign_q  <= sign_cap_q;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q <= 1'b0;
          // Back-to-back request is accepted exactly as from IDLE.
          if (start) begin
            sr_q       <= {{BCD_W{1'b0}}, operand_d};
            cnt_q      <= '0;
            sticky_q   <= 1'b0;
            sign_cap_q <= sign_d;
            busy_q     <= 1'b1;
            state_q    <= ST_SHIFT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd_out  = bcd_q;
  assign overflow = ovf_q;
  assign sign_out = sign_q;

endmodule : bin2bcd_seq

// File: tb/tb_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin2bcd_seq
// Self-checking bench for bin2bcd_seq. Instance a uses BIN_W=8/DIGITS=3,
// instance b uses BIN_W=8/DIGITS=2 for saturation. Expected results come
// from a decimal reference model (division/modulo), honouring
// BIN2BCD_SIGNED_EN when defined.
// -----------------------------------------------------------------------------
module tb_bin2bcd_seq;

  localparam int BIN_W = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, start_b;
  logic [7:0]  bin_a, bin_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [11:0] bcd_a;
  logic [7:0]  bcd_b;
  logic        ovf_a, ovf_b, sign_a, sign_b;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bin_in(bin_a),
    .busy(busy_a), .done(done_a), .bcd_out(bcd_a),
    .overflow(ovf_a), .sign_out(sign_a)
  );

  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bin_in(bin_b),
    .busy(busy_b), .done(done_b), .bcd_out(bcd_b),
    .overflow(ovf_b), .sign_out(sign_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Decimal reference: magnitude, range test, then digits by mod/div.
  task automatic ref_conv(input logic [7:0] v, input int digits,
                          output logic [11:0] bcd, output logic ov, output logic sg);
    int mag, lim, t;
    sg  = 1'b0;
    mag = int'(v);
`ifdef BIN2BCD_SIGNED_EN
    sg = v[7];
    if (sg) mag = 256 - int'(v);
`endif
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    bcd = 12'h000;
    if (mag >= lim) begin
      ov = 1'b1;
      for (int i = 0; i < digits; i++) bcd[4*i +: 4] = 4'd9;
    end else begin
      ov = 1'b0;
      t  = mag;
      for (int i = 0; i < digits; i++) begin
        bcd[4*i +: 4] = 4'(t % 10);
        t = t / 10;
      end
    end
  endtask

  function automatic logic get_done(input int which);
    return (which == 0) ? done_a : done_b;
  endfunction

  // Issue one conversion, measure edges from accept to visible done, check all.
  task automatic run_conv(input int which, input logic [7:0] v);
    logic [11:0] e_bcd;
    logic        e_ov, e_sg;
    int          lat;
    ref_conv(v, (which == 0) ? 3 : 2, e_bcd, e_ov, e_sg);
    @(negedge clk);
    if (which == 0) begin bin_a = v; start_a = 1'b1; end
    else            begin bin_b = v; start_b = 1'b1; end
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    bin_a = $urandom_range(0, 255);   // post-capture changes must not matter
    bin_b = $urandom_range(0, 255);
    check("busy_after_accept", (which == 0) ? busy_a : busy_b, 1'b1);
    lat = 0;
    while (!get_done(which) && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("latency", lat, BIN_W);
    if (which == 0) begin
      check("bcd_a", bcd_a, e_bcd);
      check("ovf_a", ovf_a, e_ov);
      check("sign_a", sign_a, e_sg);
      check("busy_at_done_a", busy_a, 1'b0);
    end else begin
      check("bcd_b", bcd_b, e_bcd[7:0]);
      check("ovf_b", ovf_b, e_ov);
      check("sign_b", sign_b, e_sg);
    end
    @(negedge clk);
    check("done_one_cycle", get_done(which), 1'b0);
  endtask

  initial begin : main
    logic [11:0] e_bcd;
    logic        e_ov, e_sg;
    logic [4:0]  bsum;
    int          t, gap, ndone;

    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; bin_a = 8'd0; bin_b = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_bcd", bcd_a, 12'h000);
    check("rst_ovf", ovf_a, 1'b0);
    check("rst_sign", sign_a, 1'b0);

    // Directed values
    run_conv(0, 8'd0);
    run_conv(0, 8'd255);
    run_conv(0, 8'd99);
    // Low digit into a BCD adder with 9: 9+9=18 -> sum digit 8
    bsum = {1'b0, bcd_a[3:0]} + 5'd9;
    if (bsum > 5'd9) bsum = bsum + 5'd6;
    check("bcd_adder_digit", bsum[3:0], 4'd8);
    run_conv(0, 8'h80);
    run_conv(1, 8'd200);
    run_conv(1, 8'd99);
    run_conv(1, 8'd100);

    // Start pulses while busy (cycles 2 and 5) with a new operand: ignored.
    ref_conv(8'd255, 3, e_bcd, e_ov, e_sg);
    @(negedge clk); bin_a = 8'd255; start_a = 1'b1;
    @(posedge clk);
    @(negedge clk); start_a = 1'b0;
    t = 0;
    while (!done_a && t < 40) begin
      @(posedge clk); t++;
      @(negedge clk);
      if (t == 2 || t == 5) begin start_a = 1'b1; bin_a = 8'd7; end
      else                  begin start_a = 1'b0; end
    end
    start_a = 1'b0;
    check("ignore_lat", t, BIN_W);
    check("ignore_bcd", bcd_a, e_bcd);
    @(negedge clk);
    check("ignore_no_extra_busy", busy_a, 1'b0);

    // Back-to-back: start held through DONE, 13 then 200.
    @(negedge clk); bin_a = 8'd13; start_a = 1'b1;
    @(posedge clk);
    @(negedge clk); bin_a = 8'd200;
    t = 0;
    while (!done_a && t < 40) begin @(negedge clk); t++; end
    ref_conv(8'd13, 3, e_bcd, e_ov, e_sg);
    check("b2b_first", bcd_a, e_bcd);
    gap = 0;
    do begin
      @(negedge clk); gap++;
      start_a = 1'b0;
    end while (!done_a && gap < 40);
    ref_conv(8'd200, 3, e_bcd, e_ov, e_sg);
    check("b2b_gap", gap, BIN_W + 1);
    check("b2b_second", bcd_a, e_bcd);

    // Randomized against the model
    for (int i = 0; i < 20; i++) run_conv(0, 8'($urandom_range(0, 255)));
    for (int i = 0; i < 8; i++)  run_conv(1, 8'($urandom_range(0, 255)));

    // Reset during iteration 4 aborts the conversion.
    @(negedge clk); bin_a = 8'd255; start_a = 1'b1;
    @(posedge clk);
    @(negedge clk); start_a = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    check("abort_busy", busy_a, 1'b0);
    check("abort_bcd", bcd_a, 12'h000);
    check("abort_ovf", ovf_a, 1'b0);
    check("abort_sign", sign_a, 1'b0);
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done_a) ndone++;
    end
    check("abort_no_done", ndone, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_bin2bcd_seq
